// File: rtl/pcpi_initiator_if.sv
// pcpi_initiator_if: request, PCPI and response signals of the PCPI issuing front end
interface pcpi_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_insn;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_busy;
  logic        pcpi_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_wr;
  logic [1:0]  rsp_status;
  modport master (
    input  req_valid, req_insn, req_rs1, req_rs2, pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready, rsp_ready,
    output req_ready, pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_valid, rsp_data, rsp_wr, rsp_status
  );
  modport slave (
    output req_valid, req_insn, req_rs1, req_rs2, pcpi_wr, pcpi_rd, pcpi_busy, pcpi_ready, rsp_ready,
    input  req_ready, pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2, rsp_valid, rsp_data, rsp_wr, rsp_status
  );
endinterface

// File: rtl/pcpi_initiator.sv
// pcpi_initiator: issues one PCPI instruction at a time, watches busy/ready with
// no-responder and hung timeouts, and returns result plus status on a response port
module pcpi_initiator #(
  parameter int TIMEOUT_CYCLES  = 16,
  parameter int MAX_BUSY_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  pcpi_initiator_if.master bus,
  output logic [15:0]      ops_completed
);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BW = $clog2(MAX_BUSY_CYCLES) + 1;
  localparam logic [1:0] ST_OK = 2'b00, ST_NORESP = 2'b01, ST_HUNG = 2'b10;
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic pv_q, pv_d, rv_q, rv_d, wr_q, wr_d;
  logic [31:0] insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;
  logic [1:0] st_q, st_d;
  logic [15:0] ops_q, ops_d;
  logic [TW-1:0] tcnt_q, tcnt_d, t_inc;
  logic [BW-1:0] bcnt_q, bcnt_d, b_inc;
  logic expired;
  assign t_inc = tcnt_q + 1'b1;
  assign b_inc = bcnt_q + 1'b1;
  assign expired = (state_q == ISSUE) ? (t_inc == TW'(TIMEOUT_CYCLES)) : (b_inc == BW'(MAX_BUSY_CYCLES));
  always_comb begin
    state_d = state_q;
    pv_d = pv_q;
    rv_d = rv_q;
    wr_d = wr_q;
    insn_d = insn_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    data_d = data_q;
    st_d = st_q;
    ops_d = ops_q;
    tcnt_d = tcnt_q;
    bcnt_d = bcnt_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = ISSUE;
        pv_d = 1'b1;
        insn_d = bus.req_insn;
        rs1_d = bus.req_rs1;
        rs2_d = bus.req_rs2;
        tcnt_d = '0;
      end
      ISSUE, BUSY: begin
        // pcpi_ready outranks both timeouts; pcpi_valid drops on the edge entering RESP
        if (bus.pcpi_ready) begin
          state_d = RESP;
          pv_d = 1'b0;
          rv_d = 1'b1;
          data_d = bus.pcpi_wr ? bus.pcpi_rd : '0;
          wr_d = bus.pcpi_wr;
          st_d = ST_OK;
        end else if (state_q == ISSUE && bus.pcpi_busy) begin
          state_d = BUSY;
          bcnt_d = '0;
        end else if (expired) begin
          state_d = RESP;
          pv_d = 1'b0;
          rv_d = 1'b1;
          data_d = '0;
          wr_d = 1'b0;
          st_d = (state_q == ISSUE) ? ST_NORESP : ST_HUNG;
        end else begin
          tcnt_d = (state_q == ISSUE) ? t_inc : tcnt_q;
          bcnt_d = (state_q == BUSY) ? b_inc : bcnt_q;
        end
      end
      RESP: if (bus.rsp_ready) begin
        state_d = IDLE;
        rv_d = 1'b0;
        ops_d = ops_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pv_q <= 1'b0;
      rv_q <= 1'b0;
      wr_q <= 1'b0;
      insn_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
      data_q <= '0;
      st_q <= ST_OK;
      ops_q <= '0;
      tcnt_q <= '0;
      bcnt_q <= '0;
    end else begin
      state_q <= state_d;
      pv_q <= pv_d;
      rv_q <= rv_d;
      wr_q <= wr_d;
      insn_q <= insn_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
      data_q <= data_d;
      st_q <= st_d;
      ops_q <= ops_d;
      tcnt_q <= tcnt_d;
      bcnt_q <= bcnt_d;
    end
  end
  assign bus.req_ready = (state_q == IDLE);
  assign bus.pcpi_valid = pv_q;
  assign bus.pcpi_insn = insn_q;
  assign bus.pcpi_rs1 = rs1_q;
  assign bus.pcpi_rs2 = rs2_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data = data_q;
  assign bus.rsp_wr = wr_q;
  assign bus.rsp_status = st_q;
  assign ops_completed = ops_q;
endmodule

// File: tb/tb_pcpi_initiator.sv
// tb_pcpi_initiator: directed scenarios for the PCPI issuing front end with a
// hand-driven coprocessor model and hand-computed expectations
module tb_pcpi_initiator;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] ops_completed;
  logic [15:0] exp_ops;
  int total = 0;
  int bad = 0;
  pcpi_initiator_if bus();
  pcpi_initiator #(.TIMEOUT_CYCLES(16), .MAX_BUSY_CYCLES(64)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ops_completed(ops_completed)
  );
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid = 1'b1;
    bus.req_insn = i;
    bus.req_rs1 = a;
    bus.req_rs2 = b;
    step;
    bus.req_valid = 1'b0;
  endtask

  task automatic pulse_ready(input logic wr, input logic [31:0] rd);
    bus.pcpi_ready = 1'b1;
    bus.pcpi_wr = wr;
    bus.pcpi_rd = rd;
    step;
    bus.pcpi_ready = 1'b0;
    bus.pcpi_wr = 1'b0;
    bus.pcpi_rd = '0;
  endtask

  task automatic drain;
    bus.rsp_ready = 1'b1;
    step;
    bus.rsp_ready = 1'b0;
    exp_ops = exp_ops + 16'd1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_insn = '0;
    bus.req_rs1 = '0;
    bus.req_rs2 = '0;
    bus.pcpi_wr = 1'b0;
    bus.pcpi_rd = '0;
    bus.pcpi_busy = 1'b0;
    bus.pcpi_ready = 1'b0;
    bus.rsp_ready = 1'b0;
    exp_ops = '0;
    step;
    step;
    reset = 1'b0;
    total++;
    if ({bus.req_ready, bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_status} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=100000", {bus.req_ready, bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_status});
    end
    total++;
    if ({bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2, bus.rsp_data} !== 128'd0) begin
      bad++;
      $display("FAIL reset_regs got=%h exp=0", {bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2, bus.rsp_data});
    end
    total++;
    if (ops_completed !== 16'd0) begin
      bad++;
      $display("FAIL reset_ops got=%0d exp=0", ops_completed);
    end
  endtask

  task automatic test_mul;
    total++;
    if (bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL mul_req_ready got=%b exp=1", bus.req_ready);
    end
    accept(32'h02000033, 32'd7, 32'd6);
    bus.pcpi_busy = 1'b1;
    total++;
    if ({bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2} !== {32'h02000033, 32'd7, 32'd6}) begin
      bad++;
      $display("FAIL mul_issue got=%h exp=%h", {bus.pcpi_insn, bus.pcpi_rs1, bus.pcpi_rs2}, {32'h02000033, 32'd7, 32'd6});
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.pcpi_valid !== 1'b1 || bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL mul_busy_cycle%0d got valid=%b req_ready=%b exp valid=1 req_ready=0", i, bus.pcpi_valid, bus.req_ready);
      end
      if (i < 2) step;
    end
    bus.pcpi_busy = 1'b0;
    total++;
    if (bus.pcpi_valid !== 1'b1) begin
      bad++;
      $display("FAIL mul_valid_ready_cycle got=%b exp=1", bus.pcpi_valid);
    end
    pulse_ready(1'b1, 32'd42);
    total++;
    if ({bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_status} !== 5'b01100) begin
      bad++;
      $display("FAIL mul_rsp_flags got=%b exp=01100", {bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_status});
    end
    total++;
    if (bus.rsp_data !== 32'd42) begin
      bad++;
      $display("FAIL mul_rsp_data got=%0d exp=42", bus.rsp_data);
    end
    drain;
    total++;
    if (ops_completed !== exp_ops || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL mul_handshake got ops=%0d rsp_valid=%b req_ready=%b exp ops=%0d rsp_valid=0 req_ready=1", ops_completed, bus.rsp_valid, bus.req_ready, exp_ops);
    end
  endtask

  task automatic test_divu;
    accept(32'h02005033, 32'd100, 32'd7);
    pulse_ready(1'b1, 32'd14);
    total++;
    if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data} !== {4'b1100, 32'd14}) begin
      bad++;
      $display("FAIL divu_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data}, {4'b1100, 32'd14});
    end
    drain;
    total++;
    if (ops_completed !== exp_ops) begin
      bad++;
      $display("FAIL divu_ops got=%0d exp=%0d", ops_completed, exp_ops);
    end
  endtask

  task automatic test_no_responder;
    int cnt;
    cnt = 0;
    accept(32'h0000000b, 32'd1, 32'd2);
    for (int i = 0; i < 40 && bus.pcpi_valid; i++) begin
      cnt++;
      step;
    end
    total++;
    if (cnt !== 16) begin
      bad++;
      $display("FAIL noresp_valid_cycles got=%0d exp=16", cnt);
    end
    total++;
    if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data} !== {4'b1001, 32'd0}) begin
      bad++;
      $display("FAIL noresp_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data}, {4'b1001, 32'd0});
    end
    drain;
  endtask

  task automatic test_hung;
    int cnt;
    cnt = 0;
    accept(32'h0000100b, 32'd3, 32'd4);
    bus.pcpi_busy = 1'b1;
    for (int i = 0; i < 100 && bus.pcpi_valid; i++) begin
      cnt++;
      step;
    end
    bus.pcpi_busy = 1'b0;
    total++;
    if (cnt !== 65) begin
      bad++;
      $display("FAIL hung_valid_cycles got=%0d exp=65", cnt);
    end
    total++;
    if ({bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data} !== {5'b01010, 32'd0}) begin
      bad++;
      $display("FAIL hung_rsp got=%h exp=%h", {bus.pcpi_valid, bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data}, {5'b01010, 32'd0});
    end
    drain;
  endtask

  task automatic test_ready_wins;
    accept(32'h0000200b, 32'd5, 32'd6);
    for (int i = 0; i < 15; i++) step;
    total++;
    if (bus.pcpi_valid !== 1'b1) begin
      bad++;
      $display("FAIL rw_issue_valid got=%b exp=1", bus.pcpi_valid);
    end
    pulse_ready(1'b1, 32'h55);
    total++;
    if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data} !== {4'b1100, 32'h55}) begin
      bad++;
      $display("FAIL rw_issue_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data}, {4'b1100, 32'h55});
    end
    drain;
    accept(32'h0000300b, 32'd8, 32'd9);
    bus.pcpi_busy = 1'b1;
    step;
    for (int i = 0; i < 63; i++) step;
    bus.pcpi_busy = 1'b0;
    total++;
    if (bus.pcpi_valid !== 1'b1) begin
      bad++;
      $display("FAIL rw_busy_valid got=%b exp=1", bus.pcpi_valid);
    end
    pulse_ready(1'b0, 32'hdead);
    total++;
    if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data} !== {4'b1000, 32'd0}) begin
      bad++;
      $display("FAIL rw_busy_rsp got=%h exp=%h", {bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data}, {4'b1000, 32'd0});
    end
    drain;
  endtask

  task automatic test_backpressure;
    accept(32'h0000400b, 32'd10, 32'd11);
    pulse_ready(1'b1, 32'h1234);
    bus.req_valid = 1'b1;
    bus.req_insn = 32'haaaa0033;
    bus.req_rs1 = 32'd20;
    bus.req_rs2 = 32'd21;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data, bus.req_ready, bus.pcpi_valid} !== {4'b1100, 32'h1234, 2'b00}) begin
        bad++;
        $display("FAIL bp_hold%0d got=%h exp=%h", i, {bus.rsp_valid, bus.rsp_wr, bus.rsp_status, bus.rsp_data, bus.req_ready, bus.pcpi_valid}, {4'b1100, 32'h1234, 2'b00});
      end
      step;
    end
    drain;
    total++;
    if (ops_completed !== exp_ops || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release got ops=%0d req_ready=%b rsp_valid=%b exp ops=%0d req_ready=1 rsp_valid=0", ops_completed, bus.req_ready, bus.rsp_valid, exp_ops);
    end
    step;
    bus.req_valid = 1'b0;
    total++;
    if (bus.pcpi_valid !== 1'b1 || bus.pcpi_insn !== 32'haaaa0033) begin
      bad++;
      $display("FAIL bp_next_accept got valid=%b insn=%h exp valid=1 insn=aaaa0033", bus.pcpi_valid, bus.pcpi_insn);
    end
    pulse_ready(1'b0, 32'd0);
    drain;
    total++;
    if (ops_completed !== exp_ops) begin
      bad++;
      $display("FAIL bp_ops got=%0d exp=%0d", ops_completed, exp_ops);
    end
  endtask

  task automatic test_reset_mid;
    accept(32'h02000033, 32'd2, 32'd3);
    bus.pcpi_busy = 1'b1;
    step;
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    bus.pcpi_busy = 1'b0;
    exp_ops = '0;
    total++;
    if ({bus.pcpi_valid, bus.rsp_valid, bus.req_ready} !== 3'b001 || ops_completed !== exp_ops) begin
      bad++;
      $display("FAIL rst_mid_state got flags=%b ops=%0d exp flags=001 ops=0", {bus.pcpi_valid, bus.rsp_valid, bus.req_ready}, ops_completed);
    end
    pulse_ready(1'b1, 32'd99);
    step;
    total++;
    if ({bus.pcpi_valid, bus.rsp_valid, bus.req_ready} !== 3'b001 || ops_completed !== exp_ops || bus.rsp_data !== 32'd0) begin
      bad++;
      $display("FAIL rst_mid_stale_ready got flags=%b ops=%0d data=%0d exp flags=001 ops=0 data=0", {bus.pcpi_valid, bus.rsp_valid, bus.req_ready}, ops_completed, bus.rsp_data);
    end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_divu;
    test_no_responder;
    test_hung;
    test_ready_wins;
    test_backpressure;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pcpi_initiator.md
Name: pcpi_initiator

Overview:
Issuing side of the PCPI coprocessor interface. It accepts one instruction request at a time (insn, rs1, rs2) over a valid/ready port and drives pcpi_valid, pcpi_insn, pcpi_rs1 and pcpi_rs2 toward the M-extension/custom coprocessor. It then tracks pcpi_busy/pcpi_ready and returns the result with a status code over a valid/ready response port. Used as the core-side PCPI front end and as the bus-level driver in coprocessor SoC benches.

Parameters:
TIMEOUT_CYCLES, 16, cycles pcpi_valid may stay high with pcpi_busy=0 and pcpi_ready=0 before declaring "no responder"
MAX_BUSY_CYCLES, 64, cycles pcpi_busy may stay high without pcpi_ready before declaring "hung"

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_insn  in  32  instruction word
req_rs1  in  32  operand 1
req_rs2  in  32  operand 2
pcpi_valid  out  1  instruction offered to coprocessor
pcpi_insn  out  32  registered instruction
pcpi_rs1  out  32  registered operand 1
pcpi_rs2  out  32  registered operand 2
pcpi_wr  in  1  coprocessor writes rd
pcpi_rd  in  32  coprocessor result
pcpi_busy  in  1  coprocessor working
pcpi_ready  in  1  coprocessor done, single-cycle pulse
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
rsp_data  out  32  result
rsp_wr  out  1  result must be written to rd
rsp_status  out  2  00 OK, 01 NO_RESPONDER, 10 HUNG, 11 unused
ops_completed  out  16  count of responses consumed, wraps 0xFFFF->0

Behaviour:
- States: IDLE, ISSUE, BUSY, RESP. All outputs are registered except req_ready.
- Reset (synchronous) leaves state=IDLE, pcpi_valid=0, pcpi_insn/rs1/rs2=0, rsp_valid=0, rsp_data=0, rsp_wr=0, rsp_status=00, ops_completed=0, and both counters cleared.
- Reset mid-operation aborts the transaction. No response is produced, and a later pcpi_ready is ignored.
- req_ready = (state==IDLE). Only one transaction is outstanding.
- IDLE: on accept, latch insn/rs1/rs2, set pcpi_valid=1 and go to ISSUE. pcpi_valid rises the cycle after the accept.
- pcpi_insn/rs1/rs2 stay stable while pcpi_valid=1.
- ISSUE:
  - pcpi_ready=1: capture the result (see RESP capture rule), status=00, go to RESP.
  - Else pcpi_busy=1: clear counter, go to BUSY.
  - Else increment timeout counter. When the counter reaches TIMEOUT_CYCLES (pcpi_valid has been high exactly TIMEOUT_CYCLES cycles), go to RESP with rsp_data=0, rsp_wr=0, status=01.
- BUSY:
  - pcpi_ready=1: capture the result, status=00, go to RESP.
  - Else increment busy counter. At MAX_BUSY_CYCLES, go to RESP with rsp_data=0, rsp_wr=0, status=10.
  - If pcpi_busy drops without pcpi_ready, keep waiting; the counter keeps running.
- pcpi_ready has priority over both timeouts in the same cycle.
- pcpi_valid clears on the same edge that enters RESP. The coprocessor returns to its own IDLE on that edge and never sees a stale pcpi_valid.
- RESP capture rule: rsp_data = pcpi_wr ? pcpi_rd : 0, and rsp_wr = pcpi_wr.
- RESP: rsp_valid=1, with data/wr/status held stable until rsp_ready. On handshake: rsp_valid=0, ops_completed+1, go to IDLE. The next request can be accepted one cycle later.
- pcpi_ready seen in IDLE or RESP is ignored.
- Counter widths are $clog2(param)+1 and must not saturate or wrap before reaching their limit.

Test Plan:
- MUL: req insn=0x02000033, rs1=7, rs2=6; model gives busy for 3 cycles, then ready+wr with rd=42 -> rsp_data=42, rsp_wr=1, status=00. pcpi_valid is high from accept+1 through the ready cycle inclusive, then low.
- DIVU: insn=0x02005033, rs1=100, rs2=7; model answers ready with rd=14 on the first ISSUE cycle, busy never seen -> rsp_data=14, status=00, no BUSY state visited.
- No responder: busy and ready stuck at 0 -> pcpi_valid high exactly 16 cycles, then rsp_status=01, rsp_data=0, rsp_wr=0.
- Hung: busy=1 forever -> after 64 busy cycles, rsp_status=10 and pcpi_valid=0. Separately, ready on the cycle the timeout fires -> status=00 (ready wins).
- Backpressure: rsp_ready=0 for 5 cycles with req_valid=1 -> rsp fields constant, req_ready=0, pcpi_valid=0. Releasing rsp_ready -> ops_completed increments by 1, next request is accepted the following cycle.
- Reset asserted in BUSY -> next edge gives pcpi_valid=0, rsp_valid=0, req_ready=1. A subsequent pcpi_ready pulse produces no response, and ops_completed stays unchanged.
